// File: rtl/teamd_async_serial_rx.sv
// Oversampling asynchronous serial receiver: start qualification, LSB-first data, stop check.
// Define TEAMD_RX_PARITY_EN to add an even-parity bit after the data and the ParityErr port.
module teamd_async_serial_rx #(
  parameter int unsigned DATA_BITS  = 7,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] iD,
  output logic                 iLoad,
  output logic                 FrameErr,
  output logic                 Busy
`ifdef TEAMD_RX_PARITY_EN
  ,
  output logic                 ParityErr
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef TEAMD_RX_PARITY_EN
    ,
    S_PARITY
`endif
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rxs;
  logic [TW-1:0]        tick, tick_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] d_nxt;
  logic                 load_nxt, ferr_nxt;
`ifdef TEAMD_RX_PARITY_EN
  logic                 pbit, pbit_nxt;
  logic                 perr_nxt;
  logic                 par_bad;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= S_IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      iD        <= '0;
      iLoad     <= 1'b0;
      FrameErr  <= 1'b0;
`ifdef TEAMD_RX_PARITY_EN
      pbit      <= 1'b0;
      ParityErr <= 1'b0;
`endif
    end else begin
      rx_meta   <= Rx;
      rxs       <= rx_meta;
      state     <= state_nxt;
      tick      <= tick_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      iD        <= d_nxt;
      iLoad     <= load_nxt;
      FrameErr  <= ferr_nxt;
`ifdef TEAMD_RX_PARITY_EN
      pbit      <= pbit_nxt;
      ParityErr <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    d_nxt       = iD;
    load_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    // Busy covers the detecting cycle itself, before the state register leaves IDLE.
    Busy        = (state != S_IDLE) || !rxs;
`ifdef TEAMD_RX_PARITY_EN
    pbit_nxt    = pbit;
    perr_nxt    = 1'b0;
    par_bad     = ^{shift, pbit};
`endif

    case (state)
      S_IDLE: begin
        tick_nxt = '0;
        if (!rxs) begin
          state_nxt = S_START;
          // The detecting cycle counts as tick 0, so START begins at tick 1.
          tick_nxt  = TW'(1);
        end
      end

      S_START: begin
        if (tick == TICK_MID) begin
          tick_nxt = '0;
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt   = S_DATA;
            bit_idx_nxt = '0;
          end
        end
      end

      S_DATA: begin
        if (tick == TICK_END) begin
          tick_nxt    = '0;
          shift_nxt   = {rxs, shift[DATA_BITS-1:1]};
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) begin
`ifdef TEAMD_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end

`ifdef TEAMD_RX_PARITY_EN
      S_PARITY: begin
        if (tick == TICK_END) begin
          tick_nxt  = '0;
          pbit_nxt  = rxs;
          state_nxt = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick == TICK_END) begin
          tick_nxt = '0;
          if (rxs) begin
            state_nxt = S_IDLE;
`ifdef TEAMD_RX_PARITY_EN
            if (par_bad) begin
              perr_nxt = 1'b1;
            end else begin
              load_nxt = 1'b1;
              d_nxt    = shift;
            end
`else
            load_nxt = 1'b1;
            d_nxt    = shift;
`endif
          end else begin
            state_nxt = S_BREAK;
            ferr_nxt  = 1'b1;
`ifdef TEAMD_RX_PARITY_EN
            perr_nxt  = par_bad;
`endif
          end
        end
      end

      S_BREAK: begin
        tick_nxt = '0;
        if (rxs) state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        tick_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_teamd_async_serial_rx.sv
// Directed bench for teamd_async_serial_rx at DATA_BITS=7, OVERSAMPLE=16.
// Event cycles are measured from the Rx drive edge: 2 synchroniser cycles + protocol cycles.
module tb_teamd_async_serial_rx;

  logic       CLK;
  logic       RESET;
  logic       Rx;
  logic [6:0] iD;
  logic       iLoad, FrameErr, Busy;
`ifdef TEAMD_RX_PARITY_EN
  logic       ParityErr;
  logic       par_flip;
  localparam int FX = 16;
`else
  localparam int FX = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int load_cyc[$];
  logic [6:0] load_val[$];
  int ferr_cnt, ferr_cyc, both_cnt, busy_rise, busy_fall, perr_cnt, perr_cyc;
  logic busy_q;
  int t0, t1;

  teamd_async_serial_rx #(.DATA_BITS(7), .OVERSAMPLE(16)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Rx       (Rx),
    .iD       (iD),
    .iLoad    (iLoad),
    .FrameErr (FrameErr),
    .Busy     (Busy)
`ifdef TEAMD_RX_PARITY_EN
    ,
    .ParityErr(ParityErr)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    busy_q   = 1'b0;
    both_cnt = 0;
    perr_cnt = 0;
    perr_cyc = -1;
  end

  always @(negedge CLK) begin
    if (iLoad) begin
      load_cyc.push_back(cyc);
      load_val.push_back(iD);
    end
    if (FrameErr) begin
      ferr_cnt = ferr_cnt + 1;
      ferr_cyc = cyc;
    end
    if (iLoad && FrameErr) both_cnt = both_cnt + 1;
`ifdef TEAMD_RX_PARITY_EN
    if (ParityErr) begin
      perr_cnt = perr_cnt + 1;
      perr_cyc = cyc;
    end
`endif
    if (Busy && !busy_q) busy_rise = cyc;
    if (!Busy && busy_q) busy_fall = cyc;
    busy_q = Busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int unsigned n);
    Rx = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    load_cyc.delete();
    load_val.delete();
    ferr_cnt  = 0;
    ferr_cyc  = -1;
    busy_rise = -1;
    busy_fall = -1;
    perr_cnt  = 0;
    perr_cyc  = -1;
  endtask

  task automatic send_frame(input logic [6:0] d, input logic stop, input int unsigned stop_len,
                            output int start);
    start = cyc;
    drive(1'b0, 16);
    for (int i = 0; i < 7; i++) drive(d[i], 16);
`ifdef TEAMD_RX_PARITY_EN
    drive((^d) ^ par_flip, 16);
`endif
    drive(stop, stop_len);
  endtask

  initial begin
    RESET = 1'b0;
    Rx    = 1'b1;
`ifdef TEAMD_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    clear_mon();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_iD",       32'(iD),       32'h0);
    check("rst_iLoad",    32'(iLoad),    32'h0);
    check("rst_FrameErr", 32'(FrameErr), 32'h0);
    check("rst_Busy",     32'(Busy),     32'h0);
    RESET = 1'b1;
    drive(1'b1, 10);

    // Good frame 7'h5A
    clear_mon();
    send_frame(7'h5A, 1'b1, 16, t0);
    drive(1'b1, 20);
    check("good_count",     32'(load_cyc.size()),    32'd1);
    check("good_value",     32'(load_val[0]),        32'h5A);
    check("good_load_cyc",  32'(load_cyc[0] - t0),   32'(138 + FX));
    check("good_busy_rise", 32'(busy_rise - t0),     32'd2);
    check("good_busy_fall", 32'(busy_fall - t0),     32'(138 + FX));
    check("good_ferr",      32'(ferr_cnt),           32'd0);

    // 4-cycle glitch: false start
    clear_mon();
    t0 = cyc;
    drive(1'b0, 4);
    drive(1'b1, 40);
    check("glitch_load",      32'(load_cyc.size()), 32'd0);
    check("glitch_ferr",      32'(ferr_cnt),        32'd0);
    check("glitch_busy_rise", 32'(busy_rise - t0),  32'd2);
    check("glitch_busy_fall", 32'(busy_fall - t0),  32'd10);

    // Framing error on 7'h11, line held low 40 cycles past the stop bit
    clear_mon();
    send_frame(7'h11, 1'b0, 56, t0);
    check("ferr_busy_hold", 32'(Busy),            32'h1);
    drive(1'b1, 20);
    check("ferr_count",     32'(ferr_cnt),         32'd1);
    check("ferr_cyc",       32'(ferr_cyc - t0),    32'(138 + FX));
    check("ferr_load",      32'(load_cyc.size()),  32'd0);
    check("ferr_iD_kept",   32'(iD),               32'h5A);
    check("ferr_busy_fall", 32'(busy_fall - t0),   32'(187 + FX));

    // Reset during data bit 3 of a 7'h2A frame
    clear_mon();
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b1, 8);
    check("mid_busy_pre", 32'(Busy), 32'h1);
    RESET = 1'b0;
    #2;
    check("mid_rst_iD",       32'(iD),       32'h0);
    check("mid_rst_iLoad",    32'(iLoad),    32'h0);
    check("mid_rst_FrameErr", 32'(FrameErr), 32'h0);
    check("mid_rst_Busy",     32'(Busy),     32'h0);
`ifdef TEAMD_RX_PARITY_EN
    check("mid_rst_ParityErr", 32'(ParityErr), 32'h0);
`endif
    Rx = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    drive(1'b1, 10);
    send_frame(7'h2A, 1'b1, 16, t0);
    drive(1'b1, 20);
    check("post_rst_count", 32'(load_cyc.size()),  32'd1);
    check("post_rst_value", 32'(load_val[0]),      32'h2A);
    check("post_rst_cyc",   32'(load_cyc[0] - t0), 32'(138 + FX));

    // Back-to-back 7'h7F then 7'h00, no idle gap
    clear_mon();
    send_frame(7'h7F, 1'b1, 16, t0);
    send_frame(7'h00, 1'b1, 16, t1);
    drive(1'b1, 40);
    check("b2b_count", 32'(load_cyc.size()),          32'd2);
    check("b2b_val0",  32'(load_val[0]),              32'h7F);
    check("b2b_val1",  32'(load_val[1]),              32'h00);
    check("b2b_cyc0",  32'(load_cyc[0] - t0),         32'(138 + FX));
    check("b2b_gap",   32'(load_cyc[1] - load_cyc[0]), 32'(144 + FX));
    check("b2b_ferr",  32'(ferr_cnt),                 32'd0);

`ifdef TEAMD_RX_PARITY_EN
    // 7'h03 has even data weight: parity bit 1 is wrong, 0 is right
    clear_mon();
    par_flip = 1'b1;
    send_frame(7'h03, 1'b1, 16, t0);
    drive(1'b1, 20);
    check("par_bad_perr", 32'(perr_cnt),         32'd1);
    check("par_bad_cyc",  32'(perr_cyc - t0),    32'd154);
    check("par_bad_load", 32'(load_cyc.size()),  32'd0);
    clear_mon();
    par_flip = 1'b0;
    send_frame(7'h03, 1'b1, 16, t0);
    drive(1'b1, 20);
    check("par_ok_load",  32'(load_cyc.size()),  32'd1);
    check("par_ok_value", 32'(load_val[0]),      32'h03);
    check("par_ok_perr",  32'(perr_cnt),         32'd0);
`endif

    check("load_ferr_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
